// File: rtl/led_frame_sequencer.sv
// Frame sequencer for the LED strip byte writer: start frame, per-LED {hdr,B,G,R}, end frame.
// Optional busy-timeout watchdog enabled by defining SEQ_WATCHDOG_EN.
module led_frame_sequencer #(
  parameter int NUM_LEDS    = 60,
  parameter int ADDR_W      = 8,
  parameter int END_BYTES   = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              seq_clk,
  input  logic              seq_reset,
  input  logic              frame_start,
  input  logic [4:0]        brightness,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              spi_start,
  output logic [7:0]        spi_data_in,
  input  logic              spi_busy,
  output logic              seq_error
);

  // state    | meaning
  // S_IDLE   | waiting for frame_start     S_START | four 0x00 start bytes
  // S_FETCH  | pixel read, 2 cycles        S_HDR/BLUE/GREEN/RED | one LED frame
  // S_END    | END_BYTES 0xFF bytes        S_DONE  | one-cycle frame_done
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_FETCH, S_HDR, S_BLUE, S_GREEN, S_RED, S_END, S_DONE
  } frame_state_t;

  typedef enum logic [1:0] {B_IDLE, B_ISSUE, B_WAIT_HI, B_WAIT_LO} byte_state_t;

  localparam int BC_MAX = (END_BYTES > 4) ? END_BYTES : 4;
  localparam int CNT_W  = $clog2(BC_MAX);

  if (NUM_LEDS < 1 || NUM_LEDS > 2**ADDR_W || END_BYTES < 1 || WDOG_CYCLES < 1) begin : g_bad_param
    $error("led_frame_sequencer: illegal parameter combination");
  end

  frame_state_t      state, state_n;
  byte_state_t       bstate, bstate_n;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] led_idx;
  logic              fetch_ph;
  logic [23:0]       colour;
  logic [4:0]        bright_lat;
  logic              byte_done, last_start, last_end, last_led, wd_hit;

  assign byte_done  = (bstate == B_WAIT_LO) && !spi_busy;
  assign last_start = (byte_cnt == CNT_W'(3));
  assign last_end   = (byte_cnt == CNT_W'(END_BYTES - 1));
  assign last_led   = (led_idx == ADDR_W'(NUM_LEDS - 1));

  always_ff @(posedge seq_clk or posedge seq_reset) begin
    if (seq_reset) begin
      state  <= S_IDLE;
      bstate <= B_IDLE;
    end else begin
      state  <= state_n;
      bstate <= bstate_n;
    end
  end

  always_comb begin
    state_n  = state;
    bstate_n = bstate;
    case (bstate)
      B_ISSUE:   bstate_n = B_WAIT_HI;
      B_WAIT_HI: if (spi_busy) bstate_n = B_WAIT_LO;
      B_WAIT_LO: if (!spi_busy) bstate_n = B_IDLE;
      default:   bstate_n = B_IDLE;
    endcase
    // Entering any byte-sending state launches its first byte with no idle gap.
    case (state)
      S_IDLE:  if (frame_start && !seq_error) begin state_n = S_START; bstate_n = B_ISSUE; end
      S_START: if (byte_done) begin
                 if (last_start) state_n = S_FETCH;
                 else            bstate_n = B_ISSUE;
               end
      S_FETCH: if (fetch_ph)  begin state_n = S_HDR;   bstate_n = B_ISSUE; end
      S_HDR:   if (byte_done) begin state_n = S_BLUE;  bstate_n = B_ISSUE; end
      S_BLUE:  if (byte_done) begin state_n = S_GREEN; bstate_n = B_ISSUE; end
      S_GREEN: if (byte_done) begin state_n = S_RED;   bstate_n = B_ISSUE; end
      S_RED:   if (byte_done) begin
                 if (last_led) begin state_n = S_END; bstate_n = B_ISSUE; end
                 else          state_n = S_FETCH;
               end
      S_END:   if (byte_done) begin
                 if (last_end) state_n = S_DONE;
                 else          bstate_n = B_ISSUE;
               end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (wd_hit) begin
      state_n  = S_DONE;
      bstate_n = B_IDLE;
    end
  end

  always_ff @(posedge seq_clk or posedge seq_reset) begin
    if (seq_reset) begin
      byte_cnt   <= '0;
      led_idx    <= '0;
      fetch_ph   <= 1'b0;
      colour     <= '0;
      bright_lat <= '0;
    end else begin
      if (state == S_IDLE && state_n == S_START) bright_lat <= brightness;
      fetch_ph <= (state == S_FETCH) && !fetch_ph;
      if (state == S_FETCH && fetch_ph) colour <= pix_data;
      if (state_n == S_DONE) begin
        byte_cnt <= '0;
        led_idx  <= '0;
      end else begin
        if (byte_done && state == S_START) byte_cnt <= last_start ? '0 : byte_cnt + 1'b1;
        if (byte_done && state == S_END)   byte_cnt <= last_end ? '0 : byte_cnt + 1'b1;
        if (byte_done && state == S_RED && !last_led) led_idx <= led_idx + 1'b1;
      end
    end
  end

  always_comb begin
    spi_data_in = 8'h00;
    case (state)
      S_HDR:   spi_data_in = {3'b111, bright_lat};
      S_BLUE:  spi_data_in = colour[7:0];
      S_GREEN: spi_data_in = colour[15:8];
      S_RED:   spi_data_in = colour[23:16];
      S_END:   spi_data_in = 8'hFF;
      default: spi_data_in = 8'h00;
    endcase
  end

  assign spi_start  = (bstate == B_ISSUE);
  assign frame_busy = (state != S_IDLE) && (state != S_DONE);
  assign frame_done = (state == S_DONE);
  assign pix_addr   = led_idx;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
  logic            err_q, in_wait;

  assign in_wait   = (bstate == B_WAIT_HI) || (bstate == B_WAIT_LO);
  assign wd_hit    = in_wait && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
  assign seq_error = err_q;

  always_ff @(posedge seq_clk or posedge seq_reset) begin
    if (seq_reset) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wdog_cnt <= (in_wait && bstate_n == bstate) ? wdog_cnt + 1'b1 : '0;
      if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: 2 LEDs, byte-writer and pixel-store models.
// Watchdog steps are included when SEQ_WATCHDOG_EN is defined.
module tb_led_frame_sequencer;
  localparam int NL = 2, AW = 8, EB = 4, WD = 64;

  logic          seq_clk = 1'b0;
  logic          seq_reset, frame_start;
  logic [4:0]    brightness;
  logic          frame_busy, frame_done, spi_start, seq_error;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data = 24'h0;
  logic [7:0]    spi_data_in;
  logic          spi_busy = 1'b0;

  led_frame_sequencer #(.NUM_LEDS(NL), .ADDR_W(AW), .END_BYTES(EB), .WDOG_CYCLES(WD)) dut (
    .seq_clk(seq_clk), .seq_reset(seq_reset), .frame_start(frame_start),
    .brightness(brightness), .frame_busy(frame_busy), .frame_done(frame_done),
    .pix_addr(pix_addr), .pix_data(pix_data), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_busy(spi_busy), .seq_error(seq_error));

  always #5 seq_clk = ~seq_clk;

  int n_cmp = 0, n_bad = 0;
  logic [23:0] mem [256];
  logic [7:0]  base [16];
  logic [7:0]  log_q [$];
  int busy_delay = 1, busy_len = 20;
  int cd = 0, hl = 0, unstable = 0, dbl = 0, viol = 0, done_cnt = 0;
  bit inflight = 0, latch_pend = 0, prev_start = 0;
  logic [7:0] lat = 8'h00;

  always @(posedge seq_clk) pix_data <= mem[pix_addr];

  // Byte writer: busy rises busy_delay cycles after start, stays high busy_len cycles.
  always @(posedge seq_clk) begin
    if (frame_done) done_cnt++;
    if (seq_reset) begin
      spi_busy <= 1'b0; inflight = 0; latch_pend = 0; prev_start = 0;
    end else begin
      if (latch_pend) begin lat = spi_data_in; log_q.push_back(lat); latch_pend = 0; end
      else if (inflight && spi_data_in !== lat) unstable++;
      if (spi_start && prev_start) dbl++;
      prev_start = spi_start;
      if (spi_start) begin
        if (inflight) viol++;
        inflight = 1; latch_pend = 1; cd = busy_delay - 1;
        if (cd == 0) begin spi_busy <= 1'b1; hl = busy_len; end
      end else if (inflight) begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin spi_busy <= 1'b1; hl = busy_len; end
        end else begin
          hl--;
          if (hl == 0) begin spi_busy <= 1'b0; inflight = 0; end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge seq_clk); #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (frame_done) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (log_q.size() >= n) ok = 1;
    end
    chk({tag, "_bytes_reached"}, ok, 1);
  endtask

  task automatic check_frame(input logic [7:0] hdr, input string tag);
    logic [7:0] e;
    chk({tag, "_byte_count"}, log_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      e = (i == 4 || i == 8) ? hdr : base[i];
      if (i < log_q.size()) chk($sformatf("%s_byte%0d", tag, i), log_q[i], e);
    end
    chk({tag, "_data_stable"}, unstable, 0);
    chk({tag, "_start_one_cycle"}, dbl, 0);
    chk({tag, "_no_start_in_flight"}, viol, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_frame_busy"}, frame_busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pix_addr"}, pix_addr, 0);
    chk({tag, "_spi_start"}, spi_start, 0);
    chk({tag, "_spi_data_in"}, spi_data_in, 0);
    chk({tag, "_seq_error"}, seq_error, 0);
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    mem[0] = 24'h112233; mem[1] = 24'hAABBCC;
    base = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h33, 8'h22, 8'h11,
             8'hFF, 8'hCC, 8'hBB, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    seq_reset = 1'b1; frame_start = 1'b0; brightness = 5'h1F;
    #1 chk_outputs_zero("reset");
    repeat (3) tick();
    seq_reset = 1'b0; tick();

    // Frame 1: extra start and brightness change mid-frame must not disturb it.
    log_q.delete(); done_cnt = 0;
    frame_start = 1'b1;
    chk("busy_in_accept_cycle", frame_busy, 0);
    tick(); frame_start = 1'b0;
    chk("busy_after_accept", frame_busy, 1);
    wait_bytes(6, "f1_mid");
    brightness = 5'h03; start_frame();
    wait_done("f1");
    chk("done_busy_low", frame_busy, 0);
    chk("done_addr_zero", pix_addr, 0);
    start_frame();
    chk("done_cycle_start_ignored", frame_busy, 0);
    repeat (40) tick();
    chk("still_idle", frame_busy, 0);
    chk("f1_done_pulses", done_cnt, 1);
    check_frame(8'hFF, "f1");

    // Frame 2 uses the new brightness; frame 3 starts in the IDLE cycle right after DONE.
    log_q.delete(); done_cnt = 0;
    start_frame();
    wait_done("f2");
    check_frame(8'hE3, "f2");
    log_q.delete();
    tick();
    start_frame();
    chk("idle_start_accepted", frame_busy, 1);
    wait_done("f3");
    check_frame(8'hE3, "f3");
    tick();
    chk("f2_f3_done_pulses", done_cnt, 2);

    // Reset while LED 0 green byte is in flight.
    brightness = 5'h1F; log_q.delete();
    start_frame();
    wait_bytes(7, "rst_mid");
    chk("green_byte_live", spi_data_in, 8'h22);
    snap = done_cnt;
    #2 seq_reset = 1'b1;
    #1 chk_outputs_zero("async_reset");
    repeat (2) tick();
    seq_reset = 1'b0;
    repeat (30) tick();
    chk("no_done_after_reset", done_cnt, snap);
    chk("idle_after_reset", frame_busy, 0);
    log_q.delete();
    start_frame();
    wait_done("f4");
    check_frame(8'hFF, "f4");

    // Slow writer: busy rises 5 cycles after start.
    tick();
    busy_delay = 5; busy_len = 3; log_q.delete();
    start_frame();
    wait_done("f5");
    check_frame(8'hFF, "f5");
    tick();

`ifdef SEQ_WATCHDOG_EN
    busy_delay = 1000000;
    start_frame();
    chk("wd_first_issue", spi_start, 1);
    repeat (WD) tick();
    chk("wd_not_yet", seq_error, 0);
    tick();
    chk("wd_error_set", seq_error, 1);
    chk("wd_done_pulse", frame_done, 1);
    chk("wd_start_low", spi_start, 0);
    tick();
    start_frame(); tick();
    chk("wd_blocks_frames", frame_busy, 0);
    chk("wd_sticky", seq_error, 1);
    seq_reset = 1'b1; tick(); seq_reset = 1'b0; tick();
    chk("wd_cleared_by_reset", seq_error, 0);
    busy_delay = 1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Frame-level controller for the LED strip byte writer: sequences start frame, per-LED frames and end frame as a stream of single-byte writes over the start/busy byte handshake.
- Fetches pixel colour from the pixel store over a 1-cycle-latency read port and prepends the global-brightness header byte to each LED.
- Sits between the pattern logic (frame_start/frame_done) and the SPI byte writer; it is the only driver of that writer's start and data inputs.

Parameters:
- NUM_LEDS, 60, LEDs on the strip; legal range 1..2**ADDR_W.
- ADDR_W, 8, pixel-store address width.
- END_BYTES, 4, count of 0xFF end-frame bytes; legal range >=1.
- WDOG_CYCLES, 4096, busy-timeout limit; used only with SEQ_WATCHDOG_EN.

Ports:
- seq_clk  in  1  sole clock; all logic on posedge.
- seq_reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  1-cycle request to send one full frame.
- brightness  in  5  global brightness; sampled on accepted frame_start.
- frame_busy  out  1  high from the cycle after accept until frame_done.
- frame_done  out  1  1-cycle pulse after the last end-frame byte completes.
- pix_addr  out  ADDR_W  pixel-store read address.
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}; valid 1 cycle after pix_addr changes.
- spi_start  out  1  byte-write request to the byte writer.
- spi_data_in  out  8  byte to send; held stable while a byte is in flight.
- spi_busy  in  1  byte-writer busy.
- seq_error  out  1  sticky watchdog error (tied 0 without SEQ_WATCHDOG_EN).

Behaviour:
- Reset (async, immediate): frame state = IDLE, byte sub-state = B_IDLE. All outputs 0: frame_busy, frame_done, pix_addr, spi_start, spi_data_in, seq_error. Counters are 0. Reset mid-frame abandons the frame, with no done pulse.
- Frame states: IDLE -> START_FR -> FETCH -> HDR -> BLUE -> GREEN -> RED -> (FETCH | END_FR) -> DONE -> IDLE.
- IDLE: frame_start=1 latches brightness and moves to START_FR. frame_busy goes 1 on the next cycle. frame_start is ignored in every other state.
- START_FR: sends 4 bytes of 0x00 (byte_cnt 0..3).
- FETCH: drives pix_addr = led_idx and waits 1 cycle, then captures pix_data into a colour register in the next cycle.
- HDR: sends {3'b111, brightness_latched}. BLUE, GREEN and RED then send B, G and R from the colour register.
- After RED: if led_idx == NUM_LEDS-1, go to END_FR. Otherwise increment led_idx and go to FETCH. led_idx never wraps within a frame.
- END_FR: sends END_BYTES bytes of 0xFF.
- DONE: frame_done=1 for one cycle, frame_busy=0 in the same cycle, pix_addr returns to 0, then IDLE. A frame_start in the DONE cycle is ignored; one in the following IDLE cycle is accepted.
- Byte sub-FSM, used for every byte:
  - B_ISSUE: spi_start=1 for exactly one cycle, with spi_data_in set in the same cycle.
  - B_WAIT_HI: spi_start=0; wait for spi_busy=1.
  - B_WAIT_LO: wait for spi_busy=0; the byte is complete.
  - spi_data_in stays unchanged from B_ISSUE until byte completion, because the writer latches data one cycle after sampling start.
  - spi_busy=1 seen during B_ISSUE still requires B_WAIT_HI to see busy=1 before moving on; that is one cycle later.
- Total bytes per frame = 4 + 4*NUM_LEDS + END_BYTES. Bytes go out strictly in order with no gaps beyond the handshake.
- Widths: byte_cnt is wide enough for max(4, END_BYTES). led_idx is ADDR_W bits.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in B_WAIT_HI and B_WAIT_LO and clears on each sub-state change.
  - Reaching WDOG_CYCLES sets seq_error=1, drops spi_start, and forces DONE, so frame_done still pulses.
  - seq_error stays set until seq_reset and blocks new frames: frame_start is ignored while seq_error=1.
- Not defined: no counter exists, seq_error is constant 0, and waits are unbounded.

Test Plan:
- Reset, then NUM_LEDS=2, END_BYTES=4, brightness=5'h1F, pix[0]=24'h112233, pix[1]=24'hAABBCC, with a writer model whose busy rises 1 cycle after start and lasts 20 cycles -> exactly 16 bytes: 00 00 00 00 FF 33 22 11 FF CC BB AA FF FF FF FF, then one frame_done pulse.
- frame_start pulsed again mid-frame and in the DONE cycle -> ignored, still 16 bytes. A pulse in the following IDLE cycle starts a second identical frame.
- brightness changed from 5'h1F to 5'h03 mid-frame -> all header bytes in the frame remain 0xFF; the next frame uses 0xE3.
- seq_reset asserted during the GREEN byte of LED 0 -> all outputs 0 asynchronously and no frame_done. A fresh frame_start then gives a full correct 16-byte frame.
- Writer model with busy delayed 5 cycles after start -> spi_start high exactly 1 cycle per byte, and spi_data_in stable until busy falls.
- SEQ_WATCHDOG_EN with WDOG_CYCLES=64 and busy stuck low -> seq_error=1 after 64 cycles, frame_done pulses, and later frame_start is ignored until reset.
